// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: load/store decode, big-endian lane selects, req/ack stall FSM.
// Optional ack watchdog with timeout_o is compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32,
  parameter int CNT_LIMIT   = 200,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           store_data_i,
  input  logic                  dmem_ack_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [31:0]           dmem_addr_o,
  output logic [3:0]            dmem_sel_o,
  output logic [31:0]           dmem_wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  misalign_o,
`ifdef MEM_TIMEOUT_EN
  output logic                  timeout_o,
`endif
  output logic                  stallreq_o
);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      ld_data_p1;
  logic             is_load, is_store, sgn, misalign, access, ack_hit;
  logic [1:0]       sz;
  logic             tmo_hit, tmo_done;

  function automatic logic [3:0] lane_sel(input logic [1:0] s, input logic [1:0] a);
    case (s)
      SZ_B:    lane_sel = 4'b1000 >> a;
      SZ_H:    lane_sel = a[1] ? 4'b0011 : 4'b1100;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] s, input logic [31:0] d);
    case (s)
      SZ_B:    store_rep = {4{d[7:0]}};
      SZ_H:    store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] s,
                                              input logic [1:0] a, input logic sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (a)
      2'b00:   b = w[31:24];
      2'b01:   b = w[23:16];
      2'b10:   b = w[15:8];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[15:0] : w[31:16];
    case (s)
      SZ_B:    load_extend = sx ? 32'($signed(b)) : {24'd0, b};
      SZ_H:    load_extend = sx ? 32'($signed(h)) : {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sgn      = 1'b0;
    sz       = SZ_W;
    case (mem_op_i)
      4'd1: begin is_load  = 1'b1; sz = SZ_B; sgn = 1'b1; end
      4'd2: begin is_load  = 1'b1; sz = SZ_B; end
      4'd3: begin is_load  = 1'b1; sz = SZ_H; sgn = 1'b1; end
      4'd4: begin is_load  = 1'b1; sz = SZ_H; end
      4'd5: begin is_load  = 1'b1; sz = SZ_W; end
      4'd6: begin is_store = 1'b1; sz = SZ_B; end
      4'd7: begin is_store = 1'b1; sz = SZ_H; end
      4'd8: begin is_store = 1'b1; sz = SZ_W; end
      default: ;
    endcase
  end

  assign misalign = (is_load | is_store) &
                    (((sz == SZ_H) & mem_addr_i[0]) | ((sz == SZ_W) & (mem_addr_i[1:0] != 2'b00)));
  assign access   = (is_load | is_store) & ~misalign;
  // Ack only counts when a request is actually on the bus.
  assign ack_hit  = dmem_ack_i & (((state_q == S_IDLE) & access) | (state_q == S_WAIT));

`ifdef MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q;
  logic            tmo_done_q;

  assign tmo_hit   = (state_q == S_WAIT) & ~dmem_ack_i & (wdog_q == WD_W'(TIMEOUT_CYC - 1));
  assign tmo_done  = tmo_done_q;
  assign timeout_o = rst_n & tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q     <= '0;
      tmo_done_q <= 1'b0;
    end else begin
      wdog_q     <= (state_q == S_WAIT) ? wdog_q + WD_W'(1) : '0;
      tmo_done_q <= tmo_hit;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign tmo_hit        = 1'b0;
  assign tmo_done       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (access) state_d = dmem_ack_i ? S_DONE : S_WAIT;
      S_WAIT: if (dmem_ack_i || tmo_hit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage boundary: ack edge latches extended load data and bumps the access counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ld_data_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (ack_hit) begin
        cnt_q <= (cnt_q >= CNT_W'(CNT_LIMIT)) ? '0 : cnt_q + CNT_W'(1);
        if (is_load) ld_data_p1 <= load_extend(dmem_rdata_i, sz, mem_addr_i[1:0], sgn);
      end
    end
  end

  assign cnt_o = cnt_q;

  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_sel_o   = '0;
    dmem_wdata_o = '0;
    wd_o         = '0;
    wreg_o       = 1'b0;
    wdata_o      = '0;
    misalign_o   = 1'b0;
    stallreq_o   = 1'b0;
    if (rst_n) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i;
      wdata_o = wdata_i;
      if (((state_q == S_IDLE) && access) || (state_q == S_WAIT)) begin
        dmem_req_o   = 1'b1;
        stallreq_o   = 1'b1;
        wreg_o       = 1'b0;
        dmem_we_o    = is_store;
        dmem_addr_o  = {mem_addr_i[31:2], 2'b00};
        dmem_sel_o   = lane_sel(sz, mem_addr_i[1:0]);
        dmem_wdata_o = is_store ? store_rep(sz, store_data_i) : 32'd0;
      end else if (state_q == S_IDLE && misalign) begin
        misalign_o = 1'b1;
        wreg_o     = 1'b0;
      end else if (state_q == S_DONE) begin
        if (is_store || tmo_done) wreg_o = 1'b0;
        if (is_load) wdata_o = ld_data_p1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of single accesses plus
// hand-written reset, counter-wrap and (optionally) watchdog sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_sel_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] cnt_o;
  logic        misalign_o, stallreq_o;
`ifdef MEM_TIMEOUT_EN
  logic        timeout_o;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_sel_o(dmem_sel_o),
    .dmem_wdata_o(dmem_wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .cnt_o(cnt_o), .misalign_o(misalign_o),
`ifdef MEM_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .stallreq_o(stallreq_o)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        wreg;
    int          dly;
    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] bus;
    logic        mis;
    logic        exp_wreg;
    logic        chk_wd;
    logic [31:0] exp_wd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int next_cnt(input int c);
    return (c >= 200) ? 0 : c + 1;
  endfunction

  task automatic run_vec(input vec_t v);
    mem_op_i     = v.op;
    mem_addr_i   = v.addr;
    store_data_i = v.sdata;
    wreg_i       = v.wreg;
    wdata_i      = 32'h5555AAAA;
    wd_i         = 5'd7;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0BAD0BAD;
    if (!v.req) begin
      dmem_ack_i = 1'b1;
      #1;
      chk({v.name, " misalign"}, 32'(misalign_o), 32'(v.mis));
      chk({v.name, " req"}, 32'(dmem_req_o), 32'd0);
      chk({v.name, " stall"}, 32'(stallreq_o), 32'd0);
      chk({v.name, " wreg_o"}, 32'(wreg_o), 32'(v.exp_wreg));
      if (v.chk_wd) chk({v.name, " wdata_o"}, wdata_o, v.exp_wd);
      @(posedge clk); @(negedge clk);
      chk({v.name, " cnt"}, cnt_o, exp_cnt);
      dmem_ack_i = 1'b0;
    end else begin
      for (int k = 0; k <= v.dly; k++) begin
        dmem_ack_i   = (k == v.dly);
        dmem_rdata_i = (k == v.dly) ? v.rdata : 32'h0BAD0BAD;
        #1;
        chk({v.name, " req"}, 32'(dmem_req_o), 32'd1);
        chk({v.name, " stall"}, 32'(stallreq_o), 32'd1);
        chk({v.name, " sel"}, 32'(dmem_sel_o), 32'(v.sel));
        chk({v.name, " we"}, 32'(dmem_we_o), 32'(v.we));
        if (v.we) chk({v.name, " bus"}, dmem_wdata_o, v.bus);
        if (k == 0) chk({v.name, " addr"}, dmem_addr_o, {v.addr[31:2], 2'b00});
        @(posedge clk); @(negedge clk);
      end
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0BAD0BAD;
      #1;
      exp_cnt = next_cnt(exp_cnt);
      chk({v.name, " done stall"}, 32'(stallreq_o), 32'd0);
      chk({v.name, " done req"}, 32'(dmem_req_o), 32'd0);
      chk({v.name, " wreg_o"}, 32'(wreg_o), 32'(v.exp_wreg));
      chk({v.name, " wd_o"}, 32'(wd_o), 32'd7);
      if (v.chk_wd) chk({v.name, " wdata_o"}, wdata_o, v.exp_wd);
      chk({v.name, " cnt"}, cnt_o, exp_cnt);
      @(posedge clk); @(negedge clk);
    end
    mem_op_i = 4'd0;
  endtask

  vec_t vecs[13];

  initial begin
    //          name      op    addr          sdata         rdata         wreg dly req we sel      bus           mis wr chk exp_wd
    vecs[0]  = '{"LB",    4'd1, 32'h103, 32'h0,        32'h123456F0, 1'b1, 0, 1'b1, 1'b0, 4'b0001, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFFFFF0};
    vecs[1]  = '{"LHU",   4'd4, 32'h102, 32'h0,        32'hAAAA8001, 1'b1, 3, 1'b1, 1'b0, 4'b0011, 32'h0,        1'b0, 1'b1, 1'b1, 32'h00008001};
    vecs[2]  = '{"SH",    4'd7, 32'h200, 32'h0000BEEF, 32'h0,        1'b1, 0, 1'b1, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{"LWmis", 4'd5, 32'h102, 32'h0,        32'h0,        1'b1, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"LB0",   4'd1, 32'h100, 32'h0,        32'h80FFFFFF, 1'b1, 1, 1'b1, 1'b0, 4'b1000, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[5]  = '{"LBU",   4'd2, 32'h101, 32'h0,        32'h12F45678, 1'b1, 0, 1'b1, 1'b0, 4'b0100, 32'h0,        1'b0, 1'b1, 1'b1, 32'h000000F4};
    vecs[6]  = '{"LH",    4'd3, 32'h200, 32'h0,        32'h9ABC1234, 1'b1, 2, 1'b1, 1'b0, 4'b1100, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFF9ABC};
    vecs[7]  = '{"LW",    4'd5, 32'h204, 32'h0,        32'hDEADBEEF, 1'b1, 0, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[8]  = '{"SB",    4'd6, 32'h303, 32'h123456A5, 32'h0,        1'b1, 1, 1'b1, 1'b1, 4'b0001, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{"SW",    4'd8, 32'h308, 32'hCAFEF00D, 32'h0,        1'b0, 0, 1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{"LHmis", 4'd3, 32'h101, 32'h0,        32'h0,        1'b1, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{"LWnowb",4'd5, 32'h400, 32'h0,        32'h00000011, 1'b0, 0, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000011};
    vecs[12] = '{"op9",   4'd9, 32'h0,   32'h0,        32'h0,        1'b1, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h5555AAAA};

    rst_n = 1'b0; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hFFFFFFFF; mem_op_i = 4'd5;
    mem_addr_i = 32'h0; store_data_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset req", 32'(dmem_req_o), 32'd0);
    chk("reset stall", 32'(stallreq_o), 32'd0);
    chk("reset wreg_o", 32'(wreg_o), 32'd0);
    chk("reset wdata_o", wdata_o, 32'd0);
    chk("reset cnt", cnt_o, 32'd0);
    mem_op_i = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset in the middle of a WAIT
    mem_op_i = 4'd5; mem_addr_i = 32'h300; dmem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midwait req", 32'(dmem_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst req drop", 32'(dmem_req_o), 32'd0);
    chk("rst stall drop", 32'(stallreq_o), 32'd0);
    chk("rst cnt", cnt_o, 32'd0);
    mem_op_i = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    #1;
    chk("post rst req", 32'(dmem_req_o), 32'd0);
    chk("post rst cnt", cnt_o, 32'd0);

    // Counter wrap with back-to-back acked stores
    for (int i = 1; i <= 201; i++) begin
      mem_op_i = 4'd8; mem_addr_i = 32'h10; store_data_i = i; dmem_ack_i = 1'b1;
      @(posedge clk); @(negedge clk);
      dmem_ack_i = 1'b0;
      #1;
      if (i == 1)   chk("wrap cnt1", cnt_o, 32'd1);
      if (i == 200) chk("wrap cnt200", cnt_o, 32'd200);
      if (i == 201) chk("wrap cnt0", cnt_o, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    mem_op_i = 4'd0;
    exp_cnt = 0;

`ifdef MEM_TIMEOUT_EN
    begin
      int cyc = 0;
      bit seen = 0;
      mem_op_i = 4'd5; mem_addr_i = 32'h500; wreg_i = 1'b1; dmem_ack_i = 1'b0;
      while (!seen && cyc < 100) begin
        #1;
        if (timeout_o) seen = 1;
        @(negedge clk);
        cyc++;
      end
      chk("timeout seen", 32'(seen), 32'd1);
      chk("timeout cycle", cyc, 32'd65);
      #1;
      chk("timeout pulse", 32'(timeout_o), 32'd0);
      chk("timeout stall", 32'(stallreq_o), 32'd0);
      chk("timeout wreg", 32'(wreg_o), 32'd0);
      chk("timeout cnt", cnt_o, 32'd0);
      mem_op_i = 4'd0;
      @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Parametrised successor to the single-word MEM-stage access logic.
- Sits between the EX/MEM pipeline register and the data cache/RAM port.
- Decodes LB/LBU/LH/LHU/LW/SB/SH/SW, generates big-endian byte-lane selects, and sign/zero-extends load data.
- Runs a req/ack handshake FSM that stalls the pipeline until the memory acknowledges; also keeps a wrapping access counter and flags misaligned accesses.

Parameters:
- REG_ADDR_W, 5: register-file address width.
- CNT_W, 32: access counter width.
- CNT_LIMIT, 200: counter wrap point; the counter counts 0..CNT_LIMIT, then returns to 0.
- TIMEOUT_CYC, 64: ack watchdog limit in cycles. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  register write enable from EX.
- wdata_i  in  32  ALU result from EX.
- mem_op_i  in  4  access code: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
- mem_addr_i  in  32  effective byte address.
- store_data_i  in  32  store source (rt).
- dmem_ack_i  in  1  memory completed the current request.
- dmem_rdata_i  in  32  read word, valid when dmem_ack_i=1.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address: {mem_addr_i[31:2], 2'b00}.
- dmem_sel_o  out  4  byte lanes; bit3 = bits[31:24].
- dmem_wdata_o  out  32  store data replicated into the lanes.
- wd_o  out  REG_ADDR_W  to WB.
- wreg_o  out  1  to WB.
- wdata_o  out  32  to WB.
- cnt_o  out  CNT_W  access counter, registered.
- misalign_o  out  1  misaligned access this cycle.
- stallreq_o  out  1  hold IF..EX/MEM stages.
- timeout_o  out  1  watchdog fired; present only with MEM_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM state = IDLE; cnt_o = 0; load-data register = 0.
  - All other outputs are combinational and are forced to 0 while rst_n=0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, op none: pass-through (wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i); no request; stallreq_o=0.
  - IDLE, valid aligned op: dmem_req_o=1 and stallreq_o=1, both combinational. If dmem_ack_i=1 at the edge, go to DONE; otherwise go to WAIT.
  - WAIT: request outputs held, derived from inputs that the stall keeps stable; stallreq_o=1. On dmem_ack_i at an edge, go to DONE.
  - DONE: dmem_req_o=0; stallreq_o=0; result presented; the pipeline advances on this edge. Go to IDLE unconditionally.
- Minimum latency is one stall cycle (ack in the request cycle). A new request is never issued in DONE.
- On the ack edge:
  - Loads: latch the extended data.
  - Every access: cnt_o = (cnt_o >= CNT_LIMIT) ? 0 : cnt_o + 1.
- Lane selects (big-endian), keyed on addr[1:0]:
  - Byte: 00→1000, 01→0100, 10→0010, 11→0001.
  - Half: addr[1]=0→1100, 1→0011.
  - Word: 1111.
- Store data replication:
  - SB: {4{b}}.
  - SH: {2{h}}.
  - SW: as is.
- Load extraction:
  - Select the lane(s) per addr.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW is unmodified.
- Load results: wdata_o = the latched data in DONE; wreg_o = wreg_i.
- Stores: wreg_o=0, regardless of wreg_i.
- Misalignment (half with addr[0]=1; word with addr[1:0]≠00):
  - misalign_o=1 combinationally in IDLE.
  - No request; no stall; wreg_o=0; counter unchanged; FSM stays in IDLE.
- dmem_ack_i while in IDLE without a request is ignored.
- Reset asserted mid-WAIT: dmem_req_o drops immediately; the access is abandoned and the counter is not incremented.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - A watchdog counts cycles spent in WAIT.
  - If it reaches TIMEOUT_CYC without an ack, timeout_o pulses for one cycle and the FSM goes to DONE with wreg_o=0 and the counter unchanged.
  - The watchdog is cleared whenever the FSM is not in WAIT.
- When not defined: no watchdog logic and no timeout_o port; WAIT persists until ack.

Test Plan:
- LB at addr 0x103, ack in the same cycle, rdata 0x123456F0 -> stallreq_o high 1 cycle, dmem_sel_o=0001, then wdata_o=0xFFFFFFF0, wreg_o=1, cnt_o 0→1.
- LHU at 0x102, ack after 3 cycles, rdata 0xAAAA8001 -> stallreq_o high 4 cycles, sel=0011, dmem_req_o held, wdata_o=0x00008001.
- SH at 0x200, store_data_i=0x0000BEEF -> dmem_we_o=1, sel=1100, dmem_wdata_o=0xBEEFBEEF, wreg_o=0.
- LW at 0x102 -> misalign_o=1, dmem_req_o=0, stallreq_o=0, wreg_o=0, cnt_o unchanged.
- 201 back-to-back acked SW accesses starting at cnt_o=0 -> cnt_o reaches 200 after the 200th access and returns to 0 on the 201st.
- rst_n pulsed low mid-WAIT -> dmem_req_o=0 immediately, FSM in IDLE, cnt_o=0. With MEM_TIMEOUT_EN, no ack for 64 cycles -> timeout_o pulses and stall releases.
